// File: rtl/can_pkg.sv
// Shared CAN definitions: CRC-15 polynomial, default stuff run length,
// de-stuffer FSM states and the bit-serial CRC-15 update.
package can_pkg;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam int          CAN_STUFF_RUN  = 5;

  typedef enum logic [1:0] {
    DS_COUNT  = 2'd0,
    DS_EXPECT = 2'd1,
    DS_ERROR  = 2'd2
  } destuff_state_t;

  // One CRC-15 step: the feedback is the incoming bit XOR the current MSB.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc_in, input logic bit_in);
    logic fb_s;
    fb_s = bit_in ^ crc_in[14];
    return {crc_in[13:0], 1'b0} ^ (fb_s ? CAN_CRC15_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Bit-serial CAN CRC-15 accumulator. A clr in the same cycle as bit_vld
// restarts from zero and folds that bit in as the first bit of the frame.
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        bit_vld,
  input  logic        bit_in,
  output logic [14:0] crc
);

  logic [14:0] crc_r;
  logic [14:0] crc_base_s;
  logic [14:0] crc_s;

  // Next remainder: optional restart, then optional one-bit update.
  always_comb begin
    crc_base_s = crc_r;
    crc_s      = crc_r;
    if (clr) begin
      crc_base_s = 15'h0000;
    end else begin
      crc_base_s = crc_r;
    end
    if (bit_vld) begin
      crc_s = crc15_step(crc_base_s, bit_in);
    end else begin
      crc_s = crc_base_s;
    end
  end

  // Remainder register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= 15'h0000;
    end else begin
      crc_r <= crc_s;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/can_destuff.sv
// CAN receive bit de-stuffer with stuff-violation detection.
// Define CAN_DESTUFF_CRC_EN to add the CRC-15 accumulator and crc/crc_zero ports.
module can_destuff
  import can_pkg::*;
#(
  parameter int RUN = CAN_STUFF_RUN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_vld,
  input  logic        sample_bit,
  input  logic        en,
  input  logic        clr,
  output logic        out_vld,
  output logic        out_bit,
  output logic        stuff_drop,
  output logic        stuff_err,
  output logic        err_flag
`ifdef CAN_DESTUFF_CRC_EN
  ,
  output logic [14:0] crc,
  output logic        crc_zero
`endif
);

  localparam int              CNT_W   = $clog2(RUN + 1);
  localparam logic [CNT_W-1:0] RUN_C  = CNT_W'(RUN);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

  destuff_state_t   state_r, state_s, cur_state_s;
  logic [CNT_W-1:0] run_r, run_s, cur_run_s;
  logic             last_r, last_s, cur_last_s;
  logic             cur_err_s;
  logic             pass_s, drop_s, viol_s;

  logic             out_vld_r, out_bit_r, stuff_drop_r, stuff_err_r, err_flag_r;

  // clr overrides the frame state first, so a coincident sample is the new frame's first bit.
  always_comb begin
    cur_state_s = state_r;
    cur_run_s   = run_r;
    cur_last_s  = last_r;
    cur_err_s   = err_flag_r;
    if (clr) begin
      cur_state_s = DS_COUNT;
      cur_run_s   = ZERO_C;
      cur_last_s  = 1'b0;
      cur_err_s   = 1'b0;
    end else begin
      cur_state_s = state_r;
      cur_run_s   = run_r;
      cur_last_s  = last_r;
      cur_err_s   = err_flag_r;
    end
  end

  // Next-state and strobe decode for one incoming bus bit.
  always_comb begin
    state_s = cur_state_s;
    run_s   = cur_run_s;
    last_s  = cur_last_s;
    pass_s  = 1'b0;
    drop_s  = 1'b0;
    viol_s  = 1'b0;
    if (sample_vld) begin
      case (cur_state_s)
        DS_COUNT: begin
          pass_s = 1'b1;
          last_s = sample_bit;
          if (!en) begin
            run_s = ONE_C;
          end else if (sample_bit != cur_last_s) begin
            run_s = ONE_C;
          end else if (cur_run_s < RUN_C) begin
            run_s = cur_run_s + ONE_C;
          end else begin
            run_s = RUN_C;
          end
          if (en && (run_s == RUN_C)) begin
            state_s = DS_EXPECT;
          end else begin
            state_s = DS_COUNT;
          end
        end
        DS_EXPECT: begin
          if (!en) begin
            pass_s  = 1'b1;
            run_s   = ONE_C;
            last_s  = sample_bit;
            state_s = DS_COUNT;
          end else if (sample_bit != cur_last_s) begin
            // The stuff bit itself opens the next run.
            drop_s  = 1'b1;
            run_s   = ONE_C;
            last_s  = sample_bit;
            state_s = DS_COUNT;
          end else begin
            viol_s  = 1'b1;
            state_s = DS_ERROR;
          end
        end
        DS_ERROR: begin
          state_s = DS_ERROR;
        end
        default: begin
          state_s = DS_COUNT;
        end
      endcase
    end else begin
      state_s = cur_state_s;
    end
  end

  // FSM and run tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= DS_COUNT;
      run_r   <= ZERO_C;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      run_r   <= run_s;
      last_r  <= last_s;
    end
  end

  // Registered output strobes and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_r    <= 1'b0;
      out_bit_r    <= 1'b0;
      stuff_drop_r <= 1'b0;
      stuff_err_r  <= 1'b0;
      err_flag_r   <= 1'b0;
    end else begin
      out_vld_r    <= pass_s;
      out_bit_r    <= pass_s ? sample_bit : out_bit_r;
      stuff_drop_r <= drop_s;
      stuff_err_r  <= viol_s;
      err_flag_r   <= cur_err_s | viol_s;
    end
  end

  assign out_vld    = out_vld_r;
  assign out_bit    = out_bit_r;
  assign stuff_drop = stuff_drop_r;
  assign stuff_err  = stuff_err_r;
  assign err_flag   = err_flag_r;

`ifdef CAN_DESTUFF_CRC_EN
  logic [14:0] crc_s;

  can_crc15 u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .bit_vld (pass_s),
    .bit_in  (sample_bit),
    .crc     (crc_s)
  );

  assign crc      = crc_s;
  assign crc_zero = (crc_s == 15'h0000);
`endif

endmodule
